lfsr_checker: RTL

- Receive-side companion of the 10-bit dither LFSR (`lfsr`) in the DDS datapath.
- Consumes the registered pseudo-random word stream and self-synchronises a shadow copy of the generator state from the stream.
- Predicts each next word, declares lock, and counts mismatches.
- Used in BIST and bring-up to prove the dither path end to end; the stream may be tapped after any pipeline stage.

---
 rtl/lfsr_pkg.sv | 36 +++
 rtl/lfsr_checker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit dither LFSR and its receive-side checker.
// Holds the word function so generator and checker can never disagree.
package lfsr_pkg;

  localparam int LFSR_W = 10;
  localparam int FB_BIT = 5;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_word(
    input logic [LFSR_W-1:0] s
  );
    logic [LFSR_W-1:0] w;
    w[0] = s[9] ^ s[0];
    w[1] = s[8] ^ s[6] ^ s[2];
    w[2] = s[7] ^ s[3] ^ s[2] ^ s[0];
    w[3] = s[9] ^ s[7] ^ s[5] ^ s[4] ^ s[1];
    w[4] = s[5] ^ s[4] ^ s[3] ^ s[2]
         ^ s[1] ^ s[0];
    w[5] = s[7] ^ s[6] ^ s[4] ^ s[3]
         ^ s[2] ^ s[1] ^ s[0];
    w[6] = s[8] ^ s[7] ^ s[6] ^ s[4]
         ^ s[3] ^ s[2] ^ s[1] ^ s[0];
    w[7] = s[9] ^ s[8] ^ s[7] ^ s[6]
         ^ s[5] ^ s[4] ^ s[3] ^ s[2]
         ^ s[0];
    w[8] = ^s;
    w[9] = s[4] ^ s[3] ^ s[2] ^ s[1];
    return w;
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the dither LFSR word stream.
// Shadows the generator state, predicts each word, tracks lock and errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              stuck
);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] r_q, r_d;
  logic [3:0]        fill_q, fill_d;
  logic [7:0]        match_q, match_d;
  logic [7:0]        miss_q, miss_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              pulse_d;
  logic              locked_q;
  logic              pulse_q;
  logic              stuck_q;
  logic [LFSR_W-1:0] pred;
  logic              hit;

  assign pred = lfsr_word(r_q);
  assign hit  = (data_in == pred);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    if (ce) begin
      unique case (state_q)
        HUNT: begin
          r_d = {data_in[FB_BIT], r_q[LFSR_W-1:1]};
          if (fill_q == 4'd9) begin
            state_d = SYNC;
            fill_d  = 4'd0;
            match_d = 8'd0;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        SYNC: begin
          r_d = {data_in[FB_BIT], r_q[LFSR_W-1:1]};
          if (r_q == '0 || !hit) begin
            match_d = 8'd0;
          end else if (match_q == 8'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            match_d = 8'd0;
            miss_d  = 8'd0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        LOCKED: begin
          // Free-running once locked, so a bad word never corrupts R.
          r_d = {pred[FB_BIT], r_q[LFSR_W-1:1]};
          if (!hit) begin
            pulse_d = 1'b1;
            if (miss_q == 8'(LOSS_CNT - 1)) begin
              state_d = HUNT;
              fill_d  = 4'd0;
              miss_d  = 8'd0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = 8'd0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    err_d = err_q;
    if (clr_cnt) begin
      err_d = {{(CNT_W-1){1'b0}}, pulse_d};
    end else if (pulse_d && err_q != '1) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      r_q      <= '0;
      fill_q   <= 4'd0;
      match_q  <= 8'd0;
      miss_q   <= 8'd0;
      err_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
      pulse_q  <= pulse_d;
      stuck_q  <= (state_d != HUNT) && (r_d == '0);
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = err_q;
  assign stuck     = stuck_q;

endmodule
